// File: rtl/qbert_jump_planner_if.sv
// Request/command bundle between the game controller, the jump planner and the sprite layer.
// The master side drives requests and sprite status; the slave side is the planner.
interface qbert_jump_planner_if #(
   parameter int NCUBES = 28
);
   logic                             game_on;
   logic                             dir_valid;
   logic [2:0]                       dir;
   logic                             freeze;
   logic                             respawn;
   logic [2:0]                       state_qb;
   logic                             done_move_qb;
   logic                             dir_ready;
   logic [NCUBES-1:0]                position_qb;
   logic [NCUBES-1:0]                e_next_qb;
   logic [2:0]                       e_jump_qb;
   logic                             e_bad_jump;
   logic [NCUBES-1:0]                visited;
   logic [$clog2(NCUBES+1)-1:0]      visited_cnt;
   logic                             win_qb;
   logic                             busy;

   modport master (
      output game_on, dir_valid, dir, freeze, respawn, state_qb, done_move_qb,
      input  dir_ready, position_qb, e_next_qb, e_jump_qb, e_bad_jump,
             visited, visited_cnt, win_qb, busy
   );

   modport slave (
      input  game_on, dir_valid, dir, freeze, respawn, state_qb, done_move_qb,
      output dir_ready, position_qb, e_next_qb, e_jump_qb, e_bad_jump,
             visited, visited_cnt, win_qb, busy
   );
endinterface

// File: rtl/qbert_jump_planner.sv
// Q*bert jump planner: turns direction requests into sprite jump commands on the cube
// pyramid, commits landings and tracks which cubes have been visited.
module qbert_jump_planner #(
   parameter int ROWS        = 7,
   parameter int ACK_TIMEOUT = 1023
) (
   input logic                clk,
   input logic                reset,
   qbert_jump_planner_if.slave bus
);
   localparam int NCUBES = ROWS * (ROWS + 1) / 2;
   localparam int CW     = $clog2(NCUBES + 1);
   localparam int TW     = $clog2(ACK_TIMEOUT + 1);
   localparam logic [NCUBES-1:0] ONE = NCUBES'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_ACK,
      S_WAIT_DONE,
      S_COMMIT
   } state_t;

   state_t            r_state;
   state_t            w_stateNext;
   logic [NCUBES-1:0] r_position;
   logic [NCUBES-1:0] r_eNext;
   logic [2:0]        r_jump;
   logic              r_badJump;
   logic [NCUBES-1:0] r_visited;
   logic [CW-1:0]     r_visitedCnt;
   logic              r_win;
   logic [TW-1:0]     r_timer;
   logic [NCUBES-1:0] w_target;
   logic              w_dirOk;
   logic              w_ready;
   logic              w_accept;
   logic              w_abort;
   logic              w_newCube;

   // Cube (r,c) lives at bit r(r-1)/2 + c - 1; an out-of-range neighbour yields all zeros.
   function automatic logic [NCUBES-1:0] targetOf(input logic [NCUBES-1:0] pos,
                                                  input logic [2:0] d);
      logic [NCUBES-1:0] t;
      int                idx;
      t = '0;
      for (int r = 1; r <= ROWS; r++) begin
         for (int c = 1; c <= r; c++) begin
            idx = -1;
            case (d)
               3'd1:    if (r < ROWS) idx = r * (r + 1) / 2 + c - 1;
               3'd2:    if (r < ROWS) idx = r * (r + 1) / 2 + c;
               3'd3:    if (c > 1)    idx = (r - 1) * (r - 2) / 2 + c - 2;
               3'd4:    if (c < r)    idx = (r - 1) * (r - 2) / 2 + c - 1;
               default: idx = -1;
            endcase
            if (idx >= 0 && ((pos >> (r * (r - 1) / 2 + c - 1)) & ONE) != '0)
               t = t | (ONE << idx);
         end
      end
      return t;
   endfunction

   assign w_target  = targetOf(r_position, bus.dir);
   assign w_dirOk   = (bus.dir >= 3'd1) && (bus.dir <= 3'd4);
   assign w_ready   = (r_state == S_IDLE) && bus.game_on && !bus.freeze &&
                      (r_position != '0) && (bus.state_qb == 3'd3) && bus.done_move_qb;
   assign w_accept  = w_ready && bus.dir_valid && w_dirOk;
   assign w_abort   = (r_state == S_WAIT_ACK) && bus.done_move_qb &&
                      (r_timer == TW'(ACK_TIMEOUT));
   assign w_newCube = (r_eNext != '0) && ((r_visited & r_eNext) == '0) &&
                      (r_visitedCnt < CW'(NCUBES));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_stateNext;
   end

   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         S_IDLE:      if (w_accept) w_stateNext = S_ISSUE;
         S_ISSUE:     w_stateNext = S_WAIT_ACK;
         S_WAIT_ACK:  if (!bus.done_move_qb) w_stateNext = S_WAIT_DONE;
                      else if (w_abort)       w_stateNext = S_IDLE;
         S_WAIT_DONE: if (bus.done_move_qb)  w_stateNext = S_COMMIT;
         S_COMMIT:    w_stateNext = S_IDLE;
         default:     w_stateNext = S_IDLE;
      endcase
      if (bus.respawn) w_stateNext = S_IDLE;
   end

   // Respawn overrides everything, including a commit landing in the same cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_position   <= ONE;
         r_eNext      <= ONE;
         r_jump       <= '0;
         r_badJump    <= 1'b0;
         r_visited    <= ONE;
         r_visitedCnt <= CW'(1);
         r_win        <= 1'b0;
         r_timer      <= '0;
      end else begin
         r_win <= r_win || (r_visitedCnt == CW'(NCUBES));
         if (bus.respawn) begin
            r_position <= ONE;
            r_eNext    <= ONE;
            r_jump     <= '0;
            r_badJump  <= 1'b0;
         end else begin
            r_jump <= '0;
            case (r_state)
               S_IDLE: begin
                  if (w_accept) begin
                     r_eNext   <= w_target;
                     r_badJump <= (w_target == '0);
                     r_jump    <= bus.dir;
                  end
               end
               S_ISSUE: r_timer <= '0;
               S_WAIT_ACK: begin
                  if (w_abort) begin
                     r_eNext   <= r_position;
                     r_badJump <= 1'b0;
                  end else if (bus.done_move_qb) begin
                     r_timer <= r_timer + TW'(1);
                  end
               end
               S_COMMIT: begin
                  r_position <= r_eNext;
                  if (w_newCube) begin
                     r_visited    <= r_visited | r_eNext;
                     r_visitedCnt <= r_visitedCnt + CW'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.dir_ready   = w_ready;
   assign bus.position_qb = r_position;
   assign bus.e_next_qb   = r_eNext;
   assign bus.e_jump_qb   = r_jump;
   assign bus.e_bad_jump  = r_badJump;
   assign bus.visited     = r_visited;
   assign bus.visited_cnt = r_visitedCnt;
   assign bus.win_qb      = r_win;
   assign bus.busy        = (r_state != S_IDLE);
endmodule

// File: tb/tb_qbert_jump_planner.sv
// Directed bench for qbert_jump_planner: walks the whole pyramid from a hand-computed
// path table and exercises bad jumps, ack timeout, respawn, freeze and async reset.
module tb_qbert_jump_planner;
   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   testCount = 0;
   int   failCount = 0;

   qbert_jump_planner_if bus ();

   qbert_jump_planner dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Path: 1=DOWN_RIGHT 2=DOWN_LEFT 3=UP_RIGHT 4=UP_LEFT; target cube and visited count after landing.
   int walkDir [35] = '{1,1,1,1,1,1,4,2,4,2,4,2,4,2,4,2,4,2,
                        3,3,3,3,3,3,1,2,1,2,4,2,3,3,1,1,3};
   int walkTgt [35] = '{2,4,7,11,16,22,16,23,17,24,18,25,19,26,20,27,21,28,
                        21,15,10,6,3,1,2,5,8,13,9,14,9,5,8,12,7};
   int walkCnt [35] = '{2,3,4,5,6,7,7,8,9,10,11,12,13,14,15,16,17,18,
                        18,19,20,21,22,22,22,23,24,25,26,27,27,27,27,28,28};

   function automatic logic [31:0] cube(input int k);
      return (k == 0) ? 32'd0 : (32'd1 << (k - 1));
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Presents one request for a cycle; returns at the negedge where the FSM is in ISSUE.
   task automatic applyStimulus(input logic [2:0] d);
      @(negedge clk);
      bus.dir_valid = 1'b1;
      bus.dir       = d;
      @(negedge clk);
      bus.dir_valid = 1'b0;
   endtask

   // Plays the sprite layer: accept (done low), then complete (done high); returns in IDLE.
   task automatic finishMove(input bit respawnAtCommit);
      @(negedge clk);
      checkOutput("jump pulse width", 32'(bus.e_jump_qb), 32'd0);
      bus.done_move_qb = 1'b0;
      @(negedge clk);
      bus.done_move_qb = 1'b1;
      @(negedge clk);
      if (respawnAtCommit) bus.respawn = 1'b1;
      @(negedge clk);
      bus.respawn = 1'b0;
   endtask

   task automatic runWalk(input int first, input int last);
      for (int i = first; i <= last; i++) begin
         int prevCnt;
         prevCnt = (i == 0) ? 2 : walkCnt[i-1];
         checkOutput($sformatf("walk%0d ready", i), 32'(bus.dir_ready), 32'd1);
         applyStimulus(3'(walkDir[i]));
         checkOutput($sformatf("walk%0d e_next", i), 32'(bus.e_next_qb), cube(walkTgt[i]));
         checkOutput($sformatf("walk%0d e_jump", i), 32'(bus.e_jump_qb), 32'(walkDir[i]));
         finishMove(1'b0);
         checkOutput($sformatf("walk%0d pos", i), 32'(bus.position_qb), cube(walkTgt[i]));
         checkOutput($sformatf("walk%0d cnt", i), 32'(bus.visited_cnt), 32'(walkCnt[i]));
         checkOutput($sformatf("walk%0d win", i), 32'(bus.win_qb), 32'(prevCnt == 28));
      end
   endtask

   initial begin
      bus.game_on      = 1'b1;
      bus.dir_valid    = 1'b0;
      bus.dir          = 3'd0;
      bus.freeze       = 1'b0;
      bus.respawn      = 1'b0;
      bus.state_qb     = 3'd3;
      bus.done_move_qb = 1'b1;

      #2 reset = 1'b0;
      #10;
      checkOutput("rst position", 32'(bus.position_qb), 32'h1);
      checkOutput("rst e_next",   32'(bus.e_next_qb),   32'h1);
      checkOutput("rst e_jump",   32'(bus.e_jump_qb),   32'd0);
      checkOutput("rst bad",      32'(bus.e_bad_jump),  32'd0);
      checkOutput("rst visited",  32'(bus.visited),     32'h1);
      checkOutput("rst cnt",      32'(bus.visited_cnt), 32'd1);
      checkOutput("rst win",      32'(bus.win_qb),      32'd0);
      checkOutput("rst busy",     32'(bus.busy),        32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("ready after rst", 32'(bus.dir_ready), 32'd1);

      applyStimulus(3'd1);
      checkOutput("dr e_next", 32'(bus.e_next_qb), 32'h2);
      checkOutput("dr e_jump", 32'(bus.e_jump_qb), 32'd1);
      checkOutput("dr busy",   32'(bus.busy),      32'd1);
      finishMove(1'b0);
      checkOutput("dr pos",     32'(bus.position_qb), 32'h2);
      checkOutput("dr visited", 32'(bus.visited),     32'h3);
      checkOutput("dr cnt",     32'(bus.visited_cnt), 32'd2);

      applyStimulus(3'd3);
      checkOutput("ur2 e_next", 32'(bus.e_next_qb),  32'd0);
      checkOutput("ur2 bad",    32'(bus.e_bad_jump), 32'd1);
      finishMove(1'b0);
      checkOutput("off pos",   32'(bus.position_qb), 32'd0);
      checkOutput("off cnt",   32'(bus.visited_cnt), 32'd2);
      checkOutput("off ready", 32'(bus.dir_ready),   32'd0);
      checkOutput("off bad",   32'(bus.e_bad_jump),  32'd1);

      @(negedge clk);
      bus.respawn = 1'b1;
      @(negedge clk);
      bus.respawn = 1'b0;
      checkOutput("respawn pos",     32'(bus.position_qb), 32'h1);
      checkOutput("respawn e_next",  32'(bus.e_next_qb),   32'h1);
      checkOutput("respawn bad",     32'(bus.e_bad_jump),  32'd0);
      checkOutput("respawn visited", 32'(bus.visited),     32'h3);

      runWalk(0, 17);

      applyStimulus(3'd2);
      checkOutput("dl28 e_next", 32'(bus.e_next_qb),  32'd0);
      checkOutput("dl28 bad",    32'(bus.e_bad_jump), 32'd1);
      repeat (1024) @(negedge clk);
      checkOutput("timeout not yet", 32'(bus.busy), 32'd1);
      @(negedge clk);
      checkOutput("timeout busy",   32'(bus.busy),        32'd0);
      checkOutput("timeout e_next", 32'(bus.e_next_qb),   32'h0800_0000);
      checkOutput("timeout bad",    32'(bus.e_bad_jump),  32'd0);
      checkOutput("timeout pos",    32'(bus.position_qb), 32'h0800_0000);

      runWalk(18, 34);
      checkOutput("full visited", 32'(bus.visited), 32'h0FFF_FFFF);

      applyStimulus(3'd1);
      bus.game_on = 1'b0;
      finishMove(1'b0);
      checkOutput("game_off pos",   32'(bus.position_qb), cube(11));
      checkOutput("game_off ready", 32'(bus.dir_ready),   32'd0);
      bus.game_on = 1'b1;
      #1;
      checkOutput("game_on ready", 32'(bus.dir_ready), 32'd1);

      bus.freeze    = 1'b1;
      bus.dir_valid = 1'b1;
      bus.dir       = 3'd1;
      #1;
      checkOutput("freeze ready", 32'(bus.dir_ready), 32'd0);
      @(negedge clk);
      checkOutput("freeze busy", 32'(bus.busy), 32'd0);
      bus.freeze = 1'b0;
      bus.dir    = 3'd5;
      #1;
      checkOutput("bad code ready", 32'(bus.dir_ready), 32'd1);
      @(negedge clk);
      checkOutput("bad code busy", 32'(bus.busy), 32'd0);
      bus.dir_valid = 1'b0;

      applyStimulus(3'd1);
      @(negedge clk);
      bus.done_move_qb = 1'b0;
      @(negedge clk);
      checkOutput("wait_done busy", 32'(bus.busy), 32'd1);
      #2 reset = 1'b0;
      #1;
      checkOutput("async pos",     32'(bus.position_qb), 32'h1);
      checkOutput("async e_next",  32'(bus.e_next_qb),   32'h1);
      checkOutput("async visited", 32'(bus.visited),     32'h1);
      checkOutput("async cnt",     32'(bus.visited_cnt), 32'd0 + 32'd1);
      checkOutput("async win",     32'(bus.win_qb),      32'd0);
      checkOutput("async busy",    32'(bus.busy),        32'd0);
      bus.done_move_qb = 1'b1;
      @(negedge clk);
      reset = 1'b1;

      applyStimulus(3'd1);
      finishMove(1'b1);
      checkOutput("collide pos",     32'(bus.position_qb), 32'h1);
      checkOutput("collide e_next",  32'(bus.e_next_qb),   32'h1);
      checkOutput("collide visited", 32'(bus.visited),     32'h1);
      checkOutput("collide cnt",     32'(bus.visited_cnt), 32'd1);
      checkOutput("collide busy",    32'(bus.busy),        32'd0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end
endmodule
